// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed 7-segment display controller.
// Segment patterns are active-high with segment A in bit 0 through G in bit 6.
package sevenseg_pkg;

  localparam logic [6:0]  SEG_OFF = 7'h7F;
  localparam logic [15:0] AN_OFF  = 16'hFFFF;

  // Entry n lights the segments for hex digit n (lowercase b and d).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/sevenseg_hex_dec.sv
// Combinational nibble to active-high segment pattern decoder.
module sevenseg_hex_dec
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = hex_to_seg(i_nib);
  end

endmodule

// File: rtl/sevenseg_mux_ctrl.sv
// Time-multiplexed 7-segment driver: double-buffered digit data swapped at frame
// boundaries, a blank cycle at the start of each slot, and PWM brightness.
module sevenseg_mux_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SLOT_CYCLES = 12500,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_hex,
  input  logic [7*NUM_DIGITS-1:0] i_raw_seg,
  input  logic [NUM_DIGITS-1:0]   i_raw_mode,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_en,
  input  logic [BRIGHT_W-1:0]     i_bright,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_pending,
  output logic                    o_frame
);

  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [DIG_W-1:0]        dig_q, dig_d;
  logic [BRIGHT_W-1:0]     phase_q, phase_d;
  logic                    frame_q, frame_d;
  logic                    pending_q, pending_d;

  logic [4*NUM_DIGITS-1:0] sh_hex_q, sh_hex_d, act_hex_q, act_hex_d;
  logic [7*NUM_DIGITS-1:0] sh_raw_q, sh_raw_d, act_raw_q, act_raw_d;
  logic [NUM_DIGITS-1:0]   sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d, act_en_q, act_en_d;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    slot_wrap;
  logic                    frame_bnd;
  logic [3:0]              cur_hex;
  logic [6:0]              cur_raw;
  logic [6:0]              dec_seg;
  logic [6:0]              pattern;
  logic                    lit;
  logic                    drive;

  // Slot, digit and PWM timing
  always_comb begin
    slot_wrap  = (slot_cnt_q == SLOT_LAST);
    frame_bnd  = slot_wrap && (dig_q == DIG_LAST);
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    dig_d      = dig_q;
    if (slot_wrap) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
    phase_d = phase_q + 1'b1;
    // Decoded from next state so the registered pulse lands on the boundary cycle itself.
    frame_d = (slot_cnt_d == SLOT_LAST) && (dig_d == DIG_LAST);
  end

  // Shadow capture and frame-synchronous transfer
  always_comb begin
    sh_hex_d  = sh_hex_q;
    sh_raw_d  = sh_raw_q;
    sh_mode_d = sh_mode_q;
    sh_dp_d   = sh_dp_q;
    sh_en_d   = sh_en_q;
    if (i_load) begin
      sh_hex_d  = i_hex;
      sh_raw_d  = i_raw_seg;
      sh_mode_d = i_raw_mode;
      sh_dp_d   = i_dp;
      sh_en_d   = i_en;
    end

    act_hex_d  = act_hex_q;
    act_raw_d  = act_raw_q;
    act_mode_d = act_mode_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    if (frame_bnd && pending_q) begin
      act_hex_d  = sh_hex_q;
      act_raw_d  = sh_raw_q;
      act_mode_d = sh_mode_q;
      act_dp_d   = sh_dp_q;
      act_en_d   = sh_en_q;
    end

    // A load on the boundary cycle wins, so it waits for the following frame.
    pending_d = i_load | (pending_q & ~frame_bnd);
  end

  sevenseg_hex_dec u_hex_dec (
    .i_nib (cur_hex),
    .o_seg (dec_seg)
  );

  // Current digit selection and output drive
  always_comb begin
    cur_hex = act_hex_q[4*int'(dig_q) +: 4];
    cur_raw = act_raw_q[7*int'(dig_q) +: 7];
    pattern = act_mode_q[dig_q] ? cur_raw : dec_seg;
    lit     = (phase_q <= i_bright);
    drive   = act_en_q[dig_q] && lit && (slot_cnt_q != '0);

    an_d  = AN_OFF[NUM_DIGITS-1:0];
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (drive) begin
      an_d[dig_q] = 1'b0;
      seg_d       = ~pattern;
      dp_d        = ~act_dp_q[dig_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      dig_q      <= '0;
      phase_q    <= '0;
      frame_q    <= 1'b0;
      pending_q  <= 1'b0;
      sh_hex_q   <= '0;
      sh_raw_q   <= '0;
      sh_mode_q  <= '0;
      sh_dp_q    <= '0;
      sh_en_q    <= '0;
      act_hex_q  <= '0;
      act_raw_q  <= '0;
      act_mode_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      an_q       <= AN_OFF[NUM_DIGITS-1:0];
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      dig_q      <= dig_d;
      phase_q    <= phase_d;
      frame_q    <= frame_d;
      pending_q  <= pending_d;
      sh_hex_q   <= sh_hex_d;
      sh_raw_q   <= sh_raw_d;
      sh_mode_q  <= sh_mode_d;
      sh_dp_q    <= sh_dp_d;
      sh_en_q    <= sh_en_d;
      act_hex_q  <= act_hex_d;
      act_raw_q  <= act_raw_d;
      act_mode_q <= act_mode_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign o_an      = an_q;
  assign o_seg     = seg_q;
  assign o_dp      = dp_q;
  assign o_pending = pending_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_sevenseg_mux_ctrl.sv
// Bench for sevenseg_mux_ctrl (4 digits, 4-cycle slots, 2-bit brightness):
// a cycle scoreboard plus directed checks of display content and timing.
module tb_sevenseg_mux_ctrl;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    logic       frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_load = 1'b0;
  logic [15:0] i_hex = '0;
  logic [27:0] i_raw_seg = '0;
  logic [3:0]  i_raw_mode = '0;
  logic [3:0]  i_dp = '0;
  logic [3:0]  i_en = '0;
  logic [1:0]  i_bright = '0;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_pending;
  logic        o_frame;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Active-low cathode patterns for hex digits 0..F.
  logic [6:0] HEXC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [6:0] rec_seg [16];
  logic [3:0] rec_an  [16];
  logic       rec_dp  [16];
  int         rec_n;

  sevenseg_mux_ctrl #(
    .NUM_DIGITS  (4),
    .SLOT_CYCLES (4),
    .BRIGHT_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_load     (i_load),
    .i_hex      (i_hex),
    .i_raw_seg  (i_raw_seg),
    .i_raw_mode (i_raw_mode),
    .i_dp       (i_dp),
    .i_en       (i_en),
    .i_bright   (i_bright),
    .o_an       (o_an),
    .o_seg      (o_seg),
    .o_dp       (o_dp),
    .o_pending  (o_pending),
    .o_frame    (o_frame)
  );

  always #5 clk = ~clk;

  // Reference model: pushes the outputs expected after each rising edge.
  initial begin : model
    logic [1:0] m_slot, m_dig, m_phase;
    logic       m_pend, lit, drive, bnd;
    logic [6:0] sh_c [4];
    logic [6:0] ac_c [4];
    logic [3:0] sh_en, ac_en, sh_dp, ac_dp;
    exp_t e;
    m_slot = '0; m_dig = '0; m_phase = '0; m_pend = 1'b0;
    sh_en = '0; ac_en = '0; sh_dp = '0; ac_dp = '0;
    for (int k = 0; k < 4; k++) begin sh_c[k] = 7'h40; ac_c[k] = 7'h40; end
    forever begin
      @(posedge clk);
      if (rst) begin
        m_slot = '0; m_dig = '0; m_phase = '0; m_pend = 1'b0;
        sh_en = '0; ac_en = '0; sh_dp = '0; ac_dp = '0;
        for (int k = 0; k < 4; k++) begin sh_c[k] = 7'h40; ac_c[k] = 7'h40; end
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, pend: 1'b0, frame: 1'b0};
      end else begin
        lit   = (m_phase <= i_bright);
        drive = ac_en[m_dig] && lit && (m_slot != 2'd0);
        e.an  = 4'hF;
        if (drive) e.an[m_dig] = 1'b0;
        e.seg = drive ? ac_c[m_dig] : 7'h7F;
        e.dp  = drive ? ~ac_dp[m_dig] : 1'b1;
        bnd   = (m_slot == 2'd3) && (m_dig == 2'd3);
        if (bnd && m_pend) begin
          ac_en = sh_en; ac_dp = sh_dp;
          for (int k = 0; k < 4; k++) ac_c[k] = sh_c[k];
        end
        m_pend = i_load ? 1'b1 : (bnd ? 1'b0 : m_pend);
        if (i_load) begin
          sh_en = i_en; sh_dp = i_dp;
          for (int k = 0; k < 4; k++)
            sh_c[k] = i_raw_mode[k] ? ~i_raw_seg[7*k +: 7] : HEXC[i_hex[4*k +: 4]];
        end
        if (m_slot == 2'd3) m_dig = m_dig + 2'd1;
        m_slot  = m_slot + 2'd1;
        m_phase = m_phase + 2'd1;
        e.frame = (m_slot == 2'd3) && (m_dig == 2'd3);
        e.pend  = m_pend;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: every cycle presents a registered output word to compare.
  initial begin : monitor
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {o_an, o_seg, o_dp, o_pending, o_frame};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got an=%h seg=%h dp=%b pend=%b frame=%b, want an=%h seg=%h dp=%b pend=%b frame=%b",
                   $time, act.an, act.seg, act.dp, act.pend, act.frame,
                   e.an, e.seg, e.dp, e.pend, e.frame);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  task automatic do_load(input logic [15:0] hex, input logic [27:0] raw, input logic [3:0] mode,
                         input logic [3:0] dp, input logic [3:0] en);
    i_hex = hex; i_raw_seg = raw; i_raw_mode = mode; i_dp = dp; i_en = en;
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_frame && n < 64);
    check(name, int'(o_frame), 1);
  endtask

  // Records every lit output cycle over one full frame of 16 cycles.
  task automatic collect();
    rec_n = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (o_an != 4'hF) begin
        rec_seg[rec_n] = o_seg;
        rec_an[rec_n]  = o_an;
        rec_dp[rec_n]  = o_dp;
        rec_n++;
      end
    end
  endtask

  task automatic count_lit(output int n);
    n = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (o_an != 4'hF) n++;
    end
  endtask

  initial begin : stimulus
    int n;
    logic [6:0] want_seg [4];
    logic [3:0] want_an  [4];
    want_seg[0] = 7'h79; want_seg[1] = 7'h08; want_seg[2] = 7'h30; want_seg[3] = 7'h0E;
    want_an[0]  = 4'hE;  want_an[1]  = 4'hD;  want_an[2]  = 4'hB;  want_an[3]  = 4'h7;

    // Reset state
    tick(); tick(); tick();
    check("reset_an", int'(o_an), 'hF);
    check("reset_seg", int'(o_seg), 'h7F);
    check("reset_dp", int'(o_dp), 1);
    check("reset_pending", int'(o_pending), 0);
    check("reset_frame", int'(o_frame), 0);
    rst = 1'b0;

    // Hex digits 1,A,3,F at full brightness
    i_bright = 2'd3;
    do_load(16'hF3A1, 28'h0, 4'h0, 4'h0, 4'hF);
    check("load_pending", int'(o_pending), 1);
    wait_frame("frame_1");
    tick();
    check("xfer_pending_clear", int'(o_pending), 0);
    collect();
    check("hex_lit_count", rec_n, 12);
    for (int i = 0; i < 12 && i < rec_n; i++) begin
      check($sformatf("hex_seg_%0d", i), int'(rec_seg[i]), int'(want_seg[i/3]));
      check($sformatf("hex_an_%0d", i), int'(rec_an[i]), int'(want_an[i/3]));
    end

    // Load issued on the frame pulse waits a whole frame
    wait_frame("frame_2");
    do_load(16'h8888, 28'h0, 4'h0, 4'h0, 4'hF);
    check("bnd_load_pending", int'(o_pending), 1);
    n = 0;
    while (o_pending && n < 40) begin
      tick();
      n++;
    end
    check("bnd_load_latency", n, 16);

    // Brightness: phase and slot counters run in lockstep here
    i_bright = 2'd0; tick(); tick();
    count_lit(n);
    check("bright0_lit", n, 0);
    i_bright = 2'd1; tick(); tick();
    count_lit(n);
    check("bright1_lit", n, 4);
    i_bright = 2'd2; tick(); tick();
    count_lit(n);
    check("bright2_lit", n, 8);

    // Raw mode, digits 1 and 3 disabled, all decimal points set
    i_bright = 2'd3;
    do_load(16'h0000, 28'hFFFFFFF, 4'hF, 4'hF, 4'b0101);
    wait_frame("frame_3");
    tick();
    collect();
    check("raw_lit_count", rec_n, 6);
    n = 0;
    for (int i = 0; i < rec_n; i++)
      if (!rec_an[i][1] || !rec_an[i][3] || rec_dp[i] || rec_seg[i] != 7'h00) n++;
    check("raw_bad_cycles", n, 0);
    n = 0;
    for (int i = 0; i < rec_n; i++) if (rec_an[i] == 4'hE) n++;
    check("raw_dp_slot0", n, 3);
    n = 0;
    for (int i = 0; i < rec_n; i++) if (rec_an[i] == 4'hB) n++;
    check("raw_dp_slot2", n, 3);

    // Second load overwrites the first before the boundary
    do_load(16'h2222, 28'h0, 4'h0, 4'h0, 4'hF);
    do_load(16'h5555, 28'h0, 4'h0, 4'h0, 4'hF);
    wait_frame("frame_4");
    tick();
    collect();
    check("overwrite_lit_count", rec_n, 12);
    n = 0;
    for (int i = 0; i < rec_n; i++) if (rec_seg[i] != 7'h12) n++;
    check("overwrite_not5", n, 0);

    // Reset while pending discards the data and blanks the display
    do_load(16'h7777, 28'h0, 4'h0, 4'h0, 4'hF);
    check("pre_rst_pending", int'(o_pending), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pending", int'(o_pending), 0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (o_an != 4'hF || o_pending) n++;
    end
    check("rst_blank_cycles", n, 0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
